// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes from the decoder and the registered
// payload carried by the execute stage.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1101;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  zero;
    logic                  overflow;
    logic                  illegal;
    logic [4:0]            rd_addr;
    logic                  reg_write;
  } alu_payload_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes result, flags and write-back info for one op.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [3:0]        alu_ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              reg_write_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              overflow_o,
  output logic              illegal_o,
  output logic [4:0]        rd_addr_o,
  output logic              reg_write_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              less;

  assign sum  = src1_i + src2_i;
  assign diff = src1_i - src2_i;
  assign less = $signed(src1_i) < $signed(src2_i);

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    illegal_o  = 1'b0;
    case (alu_ctrl_i)
      ALU_ADD: begin
        result_o   = sum;
        overflow_o = (src1_i[MSB] == src2_i[MSB]) && (sum[MSB] != src1_i[MSB]);
      end
      ALU_SUB: begin
        result_o   = diff;
        overflow_o = (src1_i[MSB] != src2_i[MSB]) && (diff[MSB] != src1_i[MSB]);
      end
      ALU_AND: result_o = src1_i & src2_i;
      ALU_OR:  result_o = src1_i | src2_i;
      ALU_NOR: result_o = ~(src1_i | src2_i);
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, less};
      default: illegal_o = 1'b1;
    endcase
  end

  // An undefined op must never reach the register file.
  assign zero_o      = (result_o == '0);
  assign rd_addr_o   = rd_addr_i;
  assign reg_write_o = reg_write_i & ~illegal_o;

endmodule

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with a registered output slot and a one-entry skid buffer
// so downstream stalls never drop an accepted op.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        alu_ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              reg_write_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              overflow_o,
  output logic              illegal_o,
  output logic [4:0]        rd_addr_o,
  output logic              reg_write_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and payload until that edge, and
  // in_ready_o depends only on registered state.

  alu_payload_t comp;
  alu_payload_t out_q, out_d;
  alu_payload_t skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_fire, out_fire;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .alu_ctrl_i  (alu_ctrl_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .rd_addr_i   (rd_addr_i),
    .reg_write_i (reg_write_i),
    .result_o    (comp.result),
    .zero_o      (comp.zero),
    .overflow_o  (comp.overflow),
    .illegal_o   (comp.illegal),
    .rd_addr_o   (comp.rd_addr),
    .reg_write_o (comp.reg_write)
  );

  assign in_ready_o = ~skid_valid_q;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = out_valid_q & out_ready_i;

  // The skid entry is always older than anything at the input, so it is
  // promoted first; in_ready_o is low whenever it is occupied.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q && out_fire) begin
      out_d        = skid_q;
      skid_valid_d = 1'b0;
    end else if (in_fire && (!out_valid_q || out_fire)) begin
      out_d       = comp;
      out_valid_d = 1'b1;
    end else if (in_fire && out_valid_q && !out_ready_i) begin
      skid_d       = comp;
      skid_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = out_q.result;
  assign zero_o      = out_q.zero;
  assign overflow_o  = out_q.overflow;
  assign illegal_o   = out_q.illegal;
  assign rd_addr_o   = out_q.rd_addr;
  assign reg_write_o = out_q.reg_write;

endmodule
